fill_responder: RTL and testbench
=================================

Name: fill_responder

Overview:
Memory-side responder for the cache line-fill interface. It accepts demand and prefetch fill requests from the cache controller over a valid/ready handshake and buffers them in a small in-order request queue. After a fixed access latency it returns each line's fill data and address to the cache over a second valid/ready handshake. It stands in for the backing store during cache bring-up and verification. Its data pattern matches the cache's fill pattern, so hit data can be checked end to end.

Parameters:
ADDR_WIDTH, 8, width of request/response address
DATA_WIDTH, 32, width of fill data; must be >= 2*ADDR_WIDTH
LATENCY, 4, access latency in cycles; legal range 1..15
QDEPTH, 4, request queue depth in entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  fill request present
req_ready  output  1  responder can complete a request handshake this cycle
req_addr  input  ADDR_WIDTH  line address requested
req_prefetch  input  1  1 = prefetch request, 0 = demand request
rsp_valid  output  1  fill response present
rsp_ready  input  1  cache accepts the response
rsp_addr  output  ADDR_WIDTH  address of returned line
rsp_data  output  DATA_WIDTH  fill data
rsp_prefetch  output  1  class of the returned request
busy  output  1  queue non-empty or service FSM not IDLE
drop_count  output  8  saturating count of dropped prefetches

Behaviour:
- Reset: all of the following clear immediately, with queued and in-flight requests discarded:
  - queue count and pointers, drop_count, rsp_valid, rsp_addr, rsp_data, rsp_prefetch, busy
  - FSM -> IDLE.
- req_ready = (count < QDEPTH), computed from the registered count. A pop in the same cycle does not raise req_ready.
- A handshake occurs when req_valid && req_ready at the rising edge.
- Demand handshake: always enqueued as {addr, prefetch=0}.
- Prefetch handshake: enqueued only if both hold:
  - count < QDEPTH-1, so one slot stays reserved for demand;
  - req_addr does not match the addr of any valid queue entry, nor the in-service addr while the FSM is WAIT/RESP.
- Otherwise the prefetch handshake still completes, the request is discarded, and drop_count increments, saturating at 255.
- Queue ordering: strict FIFO. There is no reordering between demand and prefetch requests.
- Simultaneous enqueue and pop in one cycle: count is unchanged and both operations occur.
- Service FSM:
  - IDLE: if count != 0, pop the head into the service registers, load cnt = LATENCY-1, go to WAIT.
  - WAIT: if cnt == 0 go to RESP, else decrement cnt.
  - RESP: rsp_valid = 1. On rsp_ready, go to IDLE.
- Latency: a request accepted at edge E0 into an empty, idle block raises rsp_valid after edge E0+LATENCY+1.
- Throughput: at most one response per LATENCY+2 cycles. IDLE always costs one cycle between responses.
- Response stability: rsp_valid, rsp_addr, rsp_data and rsp_prefetch are registered and held stable while rsp_valid && !rsp_ready.
- rsp_valid is low in IDLE and WAIT. rsp_addr, rsp_data and rsp_prefetch are don't-care when rsp_valid = 0.
- Data rule: rsp_data = zero-extended {rsp_addr, rsp_addr}. For the defaults this is 0x0000_AAAA, where AA is the address byte.
- Wrap-around: queue pointers wrap modulo QDEPTH; addresses are not modified.
- The queue continues to accept requests while a response is stalled by backpressure.
- busy = (count != 0) || (state != IDLE).

Test Plan:
1. Single demand: reset, then demand addr 0x12 with rsp_ready=1 -> rsp_valid rises exactly 5 edges after acceptance; rsp_addr=0x12, rsp_data=0x0000_1212, rsp_prefetch=0; busy returns to 0 one cycle after the handshake.
2. Fill and backpressure: hold rsp_ready=0, issue demands 0x01..0x05 back-to-back -> 0x01 is in service, 0x02..0x05 fill the queue, req_ready drops after 0x05; on rsp_ready=1, responses return in order 0x01..0x05 with no loss.
3. Prefetch reservation: with count=QDEPTH-1, issue prefetch 0x40 -> handshake completes, no response for 0x40, drop_count=1; a following demand 0x41 is accepted.
4. Duplicate suppression: demand 0x20 in service, then prefetch 0x20 -> dropped, drop_count increments. Then prefetch 0x24 -> responded with rsp_prefetch=1, rsp_data=0x0000_2424.
5. Reset mid-operation: three requests queued and FSM in WAIT, assert reset -> rsp_valid, busy and drop_count are 0 immediately; after release no stale responses appear; new demand 0x33 responds normally.
6. drop_count saturation: 260 rejected prefetches -> drop_count holds at 255.

Source files
------------

// File: rtl/fill_responder.sv
// Memory-side stand-in for cache line fills: in-order request queue with prefetch filtering,
// fixed-latency service FSM, registered valid/ready response carrying zero-extended {addr, addr}.
module fill_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4,
  parameter int QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_prefetch,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_prefetch,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH    = CW'(QDEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(QDEPTH - 1);
  localparam logic [3:0]    LAT_M1   = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [ADDR_WIDTH-1:0] q_addr_q [QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr_d [QDEPTH];
  logic                  q_pf_q   [QDEPTH];
  logic                  q_pf_d   [QDEPTH];
  logic                  entry_vld [QDEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_pf_q, rsp_pf_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic                  hs, dup, pf_ok, enq, drop, pop;
  logic [PW-1:0]         off;

  // Occupancy of each slot, used to restrict the duplicate-prefetch match to live entries.
  always_comb begin
    off = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      entry_vld[i] = ({1'b0, off} < count_q);
    end
  end

  always_comb begin
    dup = (state_q != ST_IDLE) && (rsp_addr_q == req_addr);
    for (int i = 0; i < QDEPTH; i++) begin
      if (entry_vld[i] && (q_addr_q[i] == req_addr)) dup = 1'b1;
    end
  end

  always_comb begin
    req_ready = (count_q < DEPTH);
    hs        = req_valid && req_ready;
    pf_ok     = (count_q < DEPTH_M1) && !dup;
    enq       = hs && (!req_prefetch || pf_ok);
    drop      = hs && req_prefetch && !pf_ok;
    pop       = (state_q == ST_IDLE) && (count_q != '0);
  end

  always_comb begin
    q_addr_d = q_addr_q;
    q_pf_d   = q_pf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      q_addr_d[wr_ptr_q] = req_addr;
      q_pf_d[wr_ptr_q]   = req_prefetch;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  // Service registers double as the response registers; the in-service address is rsp_addr_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_pf_d    = rsp_pf_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          rsp_addr_d                   = q_addr_q[rd_ptr_q];
          rsp_pf_d                     = q_pf_q[rd_ptr_q];
          rsp_data_d                   = '0;
          rsp_data_d[2*ADDR_WIDTH-1:0] = {q_addr_q[rd_ptr_q], q_addr_q[rd_ptr_q]};
          cnt_d                        = LAT_M1;
          state_d                      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_pf_q     <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_pf_q     <= rsp_pf_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Queue payload needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    q_addr_q <= q_addr_d;
    q_pf_q   <= q_pf_d;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_addr     = rsp_addr_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_prefetch = rsp_pf_q;
  assign drop_count   = drop_count_q;
  assign busy         = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fill_responder.sv
// Randomized bench for fill_responder: transaction-level reference model predicts handshake,
// drop and response timing; an independent monitor scores response contents in order.
module tb_fill_responder;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam int QD  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_prefetch;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rsp_prefetch;
  logic          busy;
  logic [7:0]    drop_count;

  fill_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_prefetch(req_prefetch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_prefetch(rsp_prefetch), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    bit            pf;
  } ent_t;

  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: pending queue, one service slot with the edge its response becomes valid.
  ent_t mq[$];
  ent_t sb[$];
  int   n_edge = 0;
  bit   m_svc  = 1'b0;
  ent_t m_cur;
  int   m_rdy  = 0;
  int   m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_rsp_valid();
    return m_svc && (n_edge >= m_rdy);
  endfunction

  task automatic check_state();
    chk("req_ready",  32'(req_ready),  32'(mq.size() < QD));
    chk("rsp_valid",  32'(rsp_valid),  32'(model_rsp_valid()));
    chk("busy",       32'(busy),       32'((mq.size() != 0) || m_svc));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // Apply one clock edge's worth of inputs to the model, all decisions taken from pre-edge state.
  task automatic model_edge(input bit v, input logic [AW-1:0] a, input bit pf, input bit rr);
    int   sz;
    bit   hs, is_dup, accept, rsp_hs, pop;
    ent_t e;
    sz     = mq.size();
    hs     = v && (sz < QD);
    is_dup = m_svc && (m_cur.a == a);
    foreach (mq[i]) if (mq[i].a == a) is_dup = 1'b1;
    accept = hs && (!pf || ((sz < QD - 1) && !is_dup));
    if (hs && !accept && m_drop < 255) m_drop++;
    rsp_hs = model_rsp_valid() && rr;
    pop    = !m_svc && (sz != 0);
    if (rsp_hs) m_svc = 1'b0;
    if (pop) begin
      m_cur = mq.pop_front();
      m_svc = 1'b1;
      m_rdy = n_edge + 1 + LAT;
    end
    if (accept) begin
      e.a  = a;
      e.pf = pf;
      mq.push_back(e);
      sb.push_back(e);
    end
    n_edge++;
  endtask

  task automatic step(input bit v, input logic [AW-1:0] a, input bit pf, input bit rr);
    @(negedge clk);
    check_state();
    req_valid    = v;
    req_addr     = a;
    req_prefetch = pf;
    rsp_ready    = rr;
    model_edge(v, a, pf, rr);
  endtask

  task automatic idle(input int k, input bit rr);
    repeat (k) step(1'b0, '0, 1'b0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_state();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    mq.delete();
    sb.delete();
    m_svc  = 1'b0;
    m_drop = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Response monitor: contents compared against the in-order expectation every cycle rsp_valid is high.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got addr 0x%0h with no request outstanding", rsp_addr);
        end else begin
          e = sb[0];
          chk("rsp_addr",     32'(rsp_addr),     32'(e.a));
          chk("rsp_data",     rsp_data,          (32'(e.a) << 8) + 32'(e.a));
          chk("rsp_prefetch", 32'(rsp_prefetch), 32'(e.pf));
          if (rsp_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_prefetch = 1'b0;
    rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("init_busy",       32'(busy),       32'd0);
    chk("init_drop_count", 32'(drop_count), 32'd0);
    chk("init_req_ready",  32'(req_ready),  32'd1);
    reset = 1'b0;

    // single demand
    step(1'b1, 8'h12, 1'b0, 1'b1);
    idle(10, 1'b1);

    // queue fill under backpressure, then in-order drain
    for (int i = 1; i <= 5; i++) step(1'b1, AW'(i), 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(40, 1'b1);

    // prefetch blocked by the demand reservation slot
    for (int i = 0; i < 4; i++) step(1'b1, AW'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b1, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    idle(40, 1'b1);

    // duplicate of the in-service line is dropped, a fresh prefetch is served
    step(1'b1, 8'h20, 1'b0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 8'h20, 1'b1, 1'b1);
    step(1'b1, 8'h24, 1'b1, 1'b1);
    idle(25, 1'b1);

    // reset with work queued and the FSM waiting
    for (int i = 0; i < 4; i++) step(1'b1, AW'(8'h60 + i), 1'b0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(10, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    idle(10, 1'b1);

    // drop_count saturation with the queue held at the reservation level
    for (int i = 0; i < 4; i++) step(1'b1, AW'(8'h70 + i), 1'b0, 1'b0);
    repeat (260) step(1'b1, AW'($urandom_range(8'h80, 8'hFF)), 1'b1, 1'b0);
    idle(40, 1'b1);
    do_reset();

    // random traffic on a narrow address range to exercise duplicates
    repeat (3000) begin
      step(($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55));
    end
    idle(200, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
